// File: rtl/dmem_io_pkg.sv
// Shared types and I/O window offsets for the data-memory / MMIO stage.
package dmem_io_pkg;
  typedef enum logic {IDLE, LOAD_WAIT} state_t;

  localparam logic [31:0] LED_OFS = 32'h0;
  localparam logic [31:0] SW_OFS  = 32'h4;
  localparam logic [31:0] CNT_OFS = 32'h8;

  typedef enum logic [2:0] {SEL_RAM, SEL_LED, SEL_SW, SEL_CNT, SEL_NONE} sel_t;
endpackage

// File: rtl/dmem_io_ram_sync.sv
// Single-port word RAM: synchronous write, registered read with read enable.
module ram_sync #(
  parameter int WORDS = 64,
  localparam int AW = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/dmem_io.sv
// Data memory + memory-mapped I/O: two-cycle loads with a one-cycle stall,
// zero-latency stores, LED/switch/cycle-counter registers.
module dmem_io
  import dmem_io_pkg::*;
#(
  parameter int          RAM_WORDS = 64,
  parameter logic [31:0] IO_BASE   = 32'h0000_0800
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  input  logic [7:0]  Switches,
  output logic [7:0]  LEDs
);
  localparam int AW = $clog2(RAM_WORDS);
  localparam logic [31:0] LED_W = (IO_BASE + LED_OFS) >> 2;
  localparam logic [31:0] SW_W  = (IO_BASE + SW_OFS)  >> 2;
  localparam logic [31:0] CNT_W = (IO_BASE + CNT_OFS) >> 2;

  state_t      state;
  sel_t        sel, sel_q;
  logic [31:0] word, io_mux, io_q, cnt, ram_rdata;
  logic [7:0]  led_q, sw_s1, sw_s2;
  logic        load, store;

  // Byte offset bits are dropped here; everything decodes on the word address.
  assign word = Addr >> 2;

  always_comb begin
    sel = SEL_NONE;
    if (word < 32'(RAM_WORDS)) sel = SEL_RAM;
    else if (word == LED_W)    sel = SEL_LED;
    else if (word == SW_W)     sel = SEL_SW;
    else if (word == CNT_W)    sel = SEL_CNT;
  end

  always_comb begin
    io_mux = '0;
    case (sel)
      SEL_LED: io_mux = {24'b0, led_q};
      SEL_SW:  io_mux = {24'b0, sw_s2};
      SEL_CNT: io_mux = cnt;
      default: io_mux = '0;
    endcase
  end

  // Store wins when both strobes are seen; nothing is accepted in LOAD_WAIT.
  assign store = reset && (state == IDLE) && MemWrite;
  assign load  = reset && (state == IDLE) && MemRead && !MemWrite;
  assign Stall = load;

  ram_sync #(.WORDS(RAM_WORDS)) u_ram (
    .clk  (clk),
    .we   (store && (sel == SEL_RAM)),
    .re   (load && (sel == SEL_RAM)),
    .addr (word[AW-1:0]),
    .wdata(WriteData),
    .rdata(ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      sel_q <= SEL_NONE;
      io_q  <= '0;
      led_q <= '0;
      cnt   <= '0;
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      sw_s1 <= Switches;
      sw_s2 <= sw_s1;
      cnt   <= (store && (sel == SEL_CNT)) ? WriteData : cnt + 32'd1;
      if (store && (sel == SEL_LED)) led_q <= WriteData[7:0];
      case (state)
        IDLE: if (load) begin
          state <= LOAD_WAIT;
          sel_q <= sel;
          io_q  <= io_mux;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Both sources are registers updated only on a load's sampling edge.
  assign ReadData = (sel_q == SEL_RAM) ? ram_rdata : io_q;
  assign LEDs     = led_q;
endmodule

// File: tb/tb_dmem_io.sv
// Directed bench for dmem_io: RAM, LED, switch, counter, reset-in-load.
module tb_dmem_io;
  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite, MemRead;
  logic [31:0] Addr, WriteData, ReadData;
  logic        Stall;
  logic [7:0]  Switches, LEDs;
  int checks = 0;
  int errors = 0;

  dmem_io dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .MemRead(MemRead),
    .Addr(Addr), .WriteData(WriteData), .ReadData(ReadData), .Stall(Stall),
    .Switches(Switches), .LEDs(LEDs)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic mr, input logic mw, input logic [31:0] a, input logic [31:0] wd);
    MemRead = mr; MemWrite = mw; Addr = a; WriteData = wd;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  // Issue a load, check the stall cycle, then the data cycle.
  task automatic do_load(input string tag, input logic [31:0] a, input logic [31:0] exp);
    drive(1, 0, a, 0);
    mid(); chk({tag, "_stall1"}, {31'b0, Stall}, 32'd1);
    nxt();
    mid(); chk({tag, "_stall0"}, {31'b0, Stall}, 32'd0);
    chk({tag, "_data"}, ReadData, exp);
    nxt();
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] wd);
    drive(0, 1, a, wd);
    mid(); chk("store_nostall", {31'b0, Stall}, 32'd0);
    nxt();
  endtask

  initial begin
    reset = 1'b0; Switches = 8'h00;
    drive(0, 0, 0, 0);
    nxt(); nxt();
    mid();
    chk("rst_rdata", ReadData, 32'h0);
    chk("rst_stall", {31'b0, Stall}, 32'h0);
    chk("rst_leds", {24'b0, LEDs}, 32'h0);
    nxt();
    reset = 1'b1;

    // RAM store then load
    do_store(32'h10, 32'hDEAD_BEEF);
    do_load("ram_load", 32'h10, 32'hDEAD_BEEF);

    // LED store/load
    do_store(32'h800, 32'h0000_00A5);
    drive(0, 0, 0, 0);
    mid(); chk("led_out", {24'b0, LEDs}, 32'hA5);
    nxt();
    do_load("led_load", 32'h800, 32'h0000_00A5);

    // Misaligned load, back-to-back with the previous one
    do_load("misalign", 32'h13, 32'hDEAD_BEEF);

    // Store straight after a load; upper bits ignored on the LED register
    do_store(32'h800, 32'hFFFF_FF5A);
    drive(0, 0, 0, 0);
    mid(); chk("led_after_load", {24'b0, LEDs}, 32'h5A);
    nxt();

    // Switch synchronizer; writes to the switch register are ignored
    Switches = 8'h3C;
    nxt(); nxt(); nxt();
    do_store(32'h804, 32'h0000_00FF);
    do_load("switch", 32'h804, 32'h0000_003C);

    // Counter load/wrap
    do_store(32'h808, 32'hFFFF_FFFE);
    drive(0, 0, 0, 0);
    nxt();
    do_load("cnt_pre", 32'h808, 32'hFFFF_FFFF);
    do_load("cnt_wrap", 32'h808, 32'h0000_0001);

    // Unmapped write is dropped and does not alias into RAM
    do_store(32'h400, 32'h1234_5678);
    do_load("ram_intact", 32'h10, 32'hDEAD_BEEF);

    // Reset during LOAD_WAIT
    drive(1, 0, 32'h800, 0);
    mid(); chk("rl_stall1", {31'b0, Stall}, 32'd1);
    nxt();
    reset = 1'b0;
    nxt();
    reset = 1'b1;
    drive(0, 0, 0, 0);
    mid();
    chk("rl_rdata", ReadData, 32'h0);
    chk("rl_stall", {31'b0, Stall}, 32'h0);
    chk("rl_leds", {24'b0, LEDs}, 32'h0);
    nxt();
    do_load("post_rst_ram", 32'h10, 32'hDEAD_BEEF);
    do_load("unmapped", 32'h400, 32'h0);

    drive(0, 0, 0, 0);
    nxt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
